// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: BCD digit inputs and display outputs between counter and scanner
interface bcd_display_scanner_if;
  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [3:0] thousands;
  logic       hold;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic       frame_done;
  logic       bad_digit;
  modport master (
    output units, tens, hundreds, thousands, hold,
    input  seg, digit_en, frame_done, bad_digit
  );
  modport slave (
    input  units, tens, hundreds, thousands, hold,
    output seg, digit_en, frame_done, bad_digit
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: 4-digit multiplexed 7-segment scanner; define LEADING_ZERO_BLANK_EN to suppress leading zeros
module bcd_display_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_display_scanner_if.slave  bus
);
  localparam int MAXN = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int W = ($clog2(MAXN) < 1) ? 1 : $clog2(MAXN);
  localparam logic [W-1:0] BLAST = W'(BLANK_CYCLES - 1);
  localparam logic [W-1:0] OLAST = W'(SCAN_DIV - 1);
  typedef enum logic {BLANK, ON} state_t;
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [1:0]   idx_q, idx_d;
  logic [15:0]  snap_q, snap_d, snap_n;
  logic [6:0]   seg_q, seg_d;
  logic [3:0]   en_q, en_d;
  logic         fd_q, fd_d, bad_q, bad_d;
  logic [3:0]   dig;
  logic         sup, blank_end, on_end;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction
  assign blank_end = (state_q == BLANK) && (cnt_q == BLAST);
  assign on_end    = (state_q == ON) && (cnt_q == OLAST);
  // Value the snapshot would take on this edge; digit 0 decodes from it so a fresh capture shows immediately
  always_comb begin
    snap_n = (idx_q == 2'd0 && !bus.hold) ? {bus.thousands, bus.hundreds, bus.tens, bus.units} : snap_q;
    dig    = snap_n[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    sup = (idx_q == 2'd3) ? (snap_n[15:12] == 4'd0) :
          (idx_q == 2'd2) ? (snap_n[15:8] == 8'd0) :
          (idx_q == 2'd1) ? (snap_n[15:4] == 12'd0) : 1'b0;
`else
    sup = 1'b0;
`endif
  end
  // Phase sequencing: BLANK then ON per digit, outputs loaded on phase edges
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    snap_d  = snap_q;
    seg_d   = seg_q;
    en_d    = en_q;
    fd_d    = 1'b0;
    bad_d   = 1'b0;
    if (blank_end) begin
      state_d = ON;
      cnt_d   = '0;
      snap_d  = snap_n;
      seg_d   = sup ? 7'h00 : dec(dig);
      en_d    = sup ? 4'h0 : (4'b0001 << idx_q);
      bad_d   = !sup && (dig > 4'd9);
    end else if (on_end) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = idx_q + 2'd1;
      seg_d   = 7'h00;
      en_d    = 4'h0;
      fd_d    = (idx_q == 2'd3);
    end
  end
  // State register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      seg_q   <= 7'h00;
      en_q    <= 4'h0;
      fd_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      bad_q   <= bad_d;
    end
  end
  assign bus.seg        = seg_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_done = fd_q;
  assign bus.bad_digit  = bad_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: scoreboard bench comparing the scanner against a frame-position model
module tb_bcd_display_scanner;
  localparam int SD = 4;
  localparam int BC = 2;
  localparam int SLOT = SD + BC;
  localparam int FRAME = 4 * SLOT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bcd_display_scanner_if bus();
  bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] dec_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0] snap [4];
  logic [12:0] q [$];
  int t = 0;
  bit started = 0;
  int vectors = 0;
  int miscompares = 0;
  // expected {seg, digit_en, frame_done, bad_digit} during cycle n after reset
  function automatic logic [12:0] expect_at(int n);
    int s, d, p;
    logic [3:0] v;
    bit sup;
    logic [6:0] sg;
    logic [3:0] en;
    s = n % FRAME;
    d = s / SLOT;
    p = s % SLOT;
    v = snap[d];
    sup = 0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      sup = 1;
      for (int k = d; k < 4; k++) if (snap[k] != 4'd0) sup = 0;
    end
`endif
    sg = (p >= BC && !sup) ? ((v > 4'd9) ? 7'h40 : dec_tab[v]) : 7'h00;
    en = (p >= BC && !sup) ? 4'(1 << d) : 4'h0;
    return {sg, en, (s == 0 && n > 0), (p == BC && !sup && v > 4'd9)};
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      t = 0;
      snap = '{4'd0, 4'd0, 4'd0, 4'd0};
      q.push_back(13'd0);
    end else if (started) begin
      if (t % FRAME == BC - 1 && !bus.hold) snap = '{bus.units, bus.tens, bus.hundreds, bus.thousands};
      t++;
      q.push_back(expect_at(t));
    end
  end
  always @(negedge clk) begin
    logic [12:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({bus.seg, bus.digit_en, bus.frame_done, bus.bad_digit} !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0d: got seg=%h en=%b fd=%b bad=%b, want seg=%h en=%b fd=%b bad=%b",
                 t, bus.seg, bus.digit_en, bus.frame_done, bus.bad_digit, e[12:6], e[5:2], e[1], e[0]);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_digits(input logic [3:0] th, input logic [3:0] h, input logic [3:0] te, input logic [3:0] u);
    bus.thousands = th;
    bus.hundreds = h;
    bus.tens = te;
    bus.units = u;
  endtask
  task automatic wait_pos(input int pos);
    int k;
    k = 0;
    while (t % FRAME != pos && k < 3 * FRAME) begin
      cyc(1);
      k++;
    end
    if (t % FRAME != pos) begin
      miscompares++;
      $display("FAIL wait_pos: frame position %0d, want %0d", t % FRAME, pos);
    end
  endtask
  initial begin
    bus.hold = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    cyc(3);
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    reset = 1'b0;
    cyc(2 * FRAME);
    set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    cyc(2 * FRAME);
    set_digits(4'd5, 4'd9, 4'd8, 4'd12);
    cyc(2 * FRAME);
    set_digits(4'd0, 4'd3, 4'd0, 4'd5);
    cyc(FRAME);
    wait_pos(2 * SLOT + BC + 1);
    bus.units = 4'd6;
    cyc(2 * FRAME);
    bus.units = 4'd5;
    cyc(FRAME);
    wait_pos(SLOT);
    bus.hold = 1'b1;
    bus.units = 4'd6;
    cyc(2 * FRAME);
    bus.hold = 1'b0;
    cyc(FRAME);
    wait_pos(10);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(2 * FRAME);
    for (int f = 0; f < 40; f++) begin
      logic [3:0] r [4];
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r[3] = 4'd0;
      set_digits(r[3], r[2], r[1], r[0]);
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 6) == 0) bus.hold = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) bus.units = 4'($urandom_range(0, 15));
        reset = ($urandom_range(0, 150) == 0);
        cyc(1);
      end
    end
    reset = 1'b0;
    cyc(2);
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL vector_count: %0d compared, want at least 12", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
